// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier controller:
//   - mult_state_e   : controller state encoding
//   - DEFAULT_WIDTH_M: default operand width / iteration count
//   - calc_cnt_w()   : width of a counter able to hold 0..width
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int DEFAULT_WIDTH_M = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mult_state_e;

  // The counter must be able to hold the full iteration count itself,
  // not just count-1, because it is loaded with WIDTH_M.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// ---------------------------------------------------------------------------
// mult_bit_counter
// Loadable down-counter holding the number of add/shift iterations left.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset (count -> 0)
//   i_clear    in   synchronous clear (count -> 0), outranks load/decrement
//   i_load     in   load i_load_val
//   i_load_val in   value loaded on i_load
//   i_dec      in   decrement by one (saturates at 0)
//   o_count    out  current count
//   o_is_one   out  count == 1, i.e. the final iteration is in progress
// ---------------------------------------------------------------------------
module mult_bit_counter
  import mult_pkg::*;
#(
  parameter int CNT_W = calc_cnt_w(DEFAULT_WIDTH_M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      // Guarded so a stray decrement can never wrap to all-ones.
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_is_one = (r_count == CNT_W'(1));

endmodule

// File: rtl/mult_controller.sv
// ---------------------------------------------------------------------------
// mult_controller
// Control FSM for a sequential shift-add multiplier. After a start request is
// accepted in IDLE it issues one LOAD, then WIDTH_M ADD/SHIFT pairs, then a
// one-cycle DONE. Outputs are Moore-decoded from the state except mux_signal,
// which passes multiplier_lsb through during ADD.
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   start          in   begin a multiplication (accepted only while ready)
//   abort          in   cancel an in-flight operation (LOAD/ADD/SHIFT)
//   multiplier_lsb in   bit 0 of the datapath multiplier shift register
//   load_signal    out  datapath operand load strobe
//   add_signal     out  datapath adder-enable strobe
//   mux_signal     out  adder input select: multiplicand (1) / zero (0)
//   shift_signal   out  datapath shift-enable strobe
//   ready          out  idle, start will be accepted
//   busy           out  operation in progress (LOAD/ADD/SHIFT)
//   done           out  one-cycle pulse, product valid on the datapath
//   bit_count      out  iterations remaining
// ---------------------------------------------------------------------------
module mult_controller
  import mult_pkg::*;
#(
  parameter  int WIDTH_M = DEFAULT_WIDTH_M,
  localparam int CNT_W   = calc_cnt_w(WIDTH_M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             multiplier_lsb,
  output logic             load_signal,
  output logic             add_signal,
  output logic             mux_signal,
  output logic             shift_signal,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
);

  if (WIDTH_M < 2) begin : g_width_check
    $error("mult_controller: WIDTH_M must be at least 2");
  end

  mult_state_e      r_state;
  mult_state_e      w_next;
  logic             w_cnt_clear;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_is_one;
  logic [CNT_W-1:0] w_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next       = r_state;
    load_signal  = 1'b0;
    add_signal   = 1'b0;
    mux_signal   = 1'b0;
    shift_signal = 1'b0;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        load_signal = 1'b1;
        busy        = 1'b1;
        w_next      = abort ? IDLE : ADD;
      end
      ADD: begin
        add_signal = 1'b1;
        mux_signal = multiplier_lsb;
        busy       = 1'b1;
        w_next     = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        shift_signal = 1'b1;
        busy         = 1'b1;
        // The count still holds the iteration being finished this cycle,
        // so is_one marks the last shift.
        if (abort) begin
          w_next = IDLE;
        end else if (w_cnt_is_one) begin
          w_next = DONE;
        end else begin
          w_next = ADD;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Counter control: loaded on leaving LOAD, decremented every SHIFT,
  // cleared when an in-flight operation is aborted.
  assign w_cnt_clear = abort && busy;
  assign w_cnt_load  = (r_state == LOAD);
  assign w_cnt_dec   = (r_state == SHIFT);

  mult_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_cnt_clear),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(WIDTH_M)),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt),
    .o_is_one   (w_cnt_is_one)
  );

  assign bit_count = w_cnt;

endmodule

// File: tb/tb_mult_controller.sv
// ---------------------------------------------------------------------------
// tb_mult_controller
// Self-checking bench. The reference model tracks an operation as a single
// cycle index t (0 = idle, 1 = load, 2..2W+1 alternating add/shift,
// 2W+2 = done) and derives every expected output arithmetically from t.
// A behavioural multiplier register supplies multiplier_lsb.
// ---------------------------------------------------------------------------
module tb_mult_controller;

  localparam int W    = 16;
  localparam int CW   = $clog2(W + 1);
  localparam int LAST = 2 * W + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          multiplier_lsb = 1'b0;
  logic          load_signal;
  logic          add_signal;
  logic          mux_signal;
  logic          shift_signal;
  logic          ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  int            base     = 0;
  int            m_t      = 0;
  logic [W-1:0]  mreg     = '0;
  logic [W-1:0]  next_op  = '0;
  int            done_q[$];
  int            load_q[$];
  int            mux_hits = 0;

  mult_controller #(
    .WIDTH_M (W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .multiplier_lsb (multiplier_lsb),
    .load_signal    (load_signal),
    .add_signal     (add_signal),
    .mux_signal     (mux_signal),
    .shift_signal   (shift_signal),
    .ready          (ready),
    .busy           (busy),
    .done           (done),
    .bit_count      (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc - base);
  endtask

  function automatic bit is_busy(input int t);
    return (t >= 1) && (t <= 2 * W + 1);
  endfunction

  function automatic bit is_add(input int t);
    return (t >= 2) && (t <= 2 * W + 1) && (t % 2 == 0);
  endfunction

  function automatic bit is_shift(input int t);
    return (t >= 2) && (t <= 2 * W + 1) && (t % 2 == 1);
  endfunction

  // Iterations remaining: W during the first add/shift pair, one less per pair.
  function automatic int exp_count(input int t);
    if (is_add(t) || is_shift(t)) return W - (t - 2) / 2;
    return 0;
  endfunction

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic begin_scn();
    done_q.delete();
    load_q.delete();
    mux_hits = 0;
    base     = cyc;
  endtask

  // One clock cycle: present lsb, compare at the falling edge, then advance
  // the model at the rising edge using the inputs driven for this cycle.
  task automatic tick();
    multiplier_lsb = mreg[0];
    @(negedge clk);
    check("ready",     int'(ready),        int'(m_t == 0));
    check("busy",      int'(busy),         int'(is_busy(m_t)));
    check("load",      int'(load_signal),  int'(m_t == 1));
    check("add",       int'(add_signal),   int'(is_add(m_t)));
    check("shift",     int'(shift_signal), int'(is_shift(m_t)));
    check("mux",       int'(mux_signal),   int'(is_add(m_t) && mreg[0]));
    check("done",      int'(done),         int'(m_t == LAST));
    check("bit_count", int'(bit_count),    exp_count(m_t));
    check("onehot", int'((int'(load_signal) + int'(add_signal) + int'(shift_signal)) <= 1), 1);
    if (done)        done_q.push_back(cyc - base);
    if (load_signal) load_q.push_back(cyc - base);
    if (mux_signal)  mux_hits++;
    @(posedge clk);
    if (m_t == 1)           mreg = next_op;
    else if (is_shift(m_t)) mreg = mreg >> 1;
    if (reset)                         m_t = 0;
    else if (abort && is_busy(m_t))    m_t = 0;
    else if (m_t == 0)                 m_t = start ? 1 : 0;
    else if (m_t == LAST)              m_t = 0;
    else                               m_t = m_t + 1;
    cyc++;
    #1;
  endtask

  initial begin
    // Reset and idle
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    begin_scn();
    repeat (5) tick();
    check("rst_ready", int'(ready), 1);
    check("rst_bit_count", int'(bit_count), 0);

    // Single operation, multiplier 0x000B
    next_op = 16'h000B;
    begin_scn();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (36) tick();
    check("s1_ndone", done_q.size(), 1);
    check("s1_done_cyc", qat(done_q, 0), 34);
    check("s1_load_cyc", qat(load_q, 0), 1);
    check("s1_mux_hits", mux_hits, 3);

    // start held high for 80 cycles
    next_op = W'($urandom);
    begin_scn();
    start = 1'b1;
    repeat (80) tick();
    start = 1'b0;
    check("s2_ndone", done_q.size(), 2);
    check("s2_done0", qat(done_q, 0), 34);
    check("s2_done1", qat(done_q, 1), 69);
    check("s2_load0", qat(load_q, 0), 1);
    check("s2_load1", qat(load_q, 1), 36);
    repeat (40) tick();

    // abort in the 5th SHIFT cycle (cycle 11)
    next_op = W'($urandom);
    begin_scn();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("s3_in_shift", int'(shift_signal), 1);
    check("s3_count_pre", int'(bit_count), 12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s3_ready", int'(ready), 1);
    check("s3_bit_count", int'(bit_count), 0);
    repeat (5) tick();
    check("s3_ndone", done_q.size(), 0);
    begin_scn();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (36) tick();
    check("s3_rerun_done", qat(done_q, 0), 34);

    // reset during ADD with start high, then start during DONE
    begin_scn();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("s4_in_add", int'(add_signal), 1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("s4_ready", int'(ready), 1);
    check("s4_add", int'(add_signal), 0);
    check("s4_bit_count", int'(bit_count), 0);
    repeat (5) tick();
    check("s4_ndone", done_q.size(), 0);
    begin_scn();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (33) tick();
    check("s4_done_now", int'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("s4_nload", load_q.size(), 1);
    check("s4_ndone2", done_q.size(), 1);

    // Randomized traffic
    begin_scn();
    repeat (2000) begin
      start   = ($urandom_range(3) == 0);
      abort   = ($urandom_range(63) == 0);
      reset   = ($urandom_range(255) == 0);
      next_op = W'($urandom);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_controller.md
Name: mult_controller

Overview:
Control FSM for the sequential shift-add multiplier. It sits directly upstream of the multiplier datapath and drives its add_signal, shift_signal and mux_signal strobes. It accepts a start request through a ready/start handshake and sequences WIDTH_M add/shift iterations using the datapath's current multiplier LSB. It reports completion with a one-cycle done pulse.

Parameters:
WIDTH_M, 16, operand width; the number of add/shift iterations per multiplication (must be >= 2)
CNT_W, $clog2(WIDTH_M+1), derived localparam; width of the iteration counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
start  input  1  request to begin a multiplication; accepted only while ready=1
abort  input  1  synchronous cancel of an in-flight operation
multiplier_lsb  input  1  current bit 0 of the datapath multiplier/shift register
load_signal  output  1  datapath operand load strobe
add_signal  output  1  datapath adder-enable strobe
mux_signal  output  1  selects multiplicand (1) or zero (0) as the adder input
shift_signal  output  1  datapath shift-enable strobe
ready  output  1  controller idle and able to accept start
busy  output  1  operation in progress (LOAD/ADD/SHIFT)
done  output  1  one-cycle pulse: product is valid on the datapath this cycle
bit_count  output  CNT_W  iterations remaining (debug/observability)

Behaviour:
- Interface: one clock clk; reset is synchronous, active-high.
- States: IDLE, LOAD, ADD, SHIFT, DONE. State register and bit_count are registered. All outputs are decoded from the state (Moore), except mux_signal.
- Output decode:
  - IDLE: ready=1.
  - LOAD: load_signal=1, busy=1.
  - ADD: add_signal=1, busy=1, mux_signal=multiplier_lsb (combinational pass-through, ADD only).
  - SHIFT: shift_signal=1, busy=1.
  - DONE: done=1.
  - Every output not listed for a state is 0 in that state.
- Transitions:
  - IDLE -> LOAD when start=1. Otherwise stay in IDLE.
  - LOAD -> ADD. bit_count loads WIDTH_M.
  - ADD -> SHIFT.
  - SHIFT -> ADD if bit_count != 1, else SHIFT -> DONE. bit_count decrements on every SHIFT cycle.
  - DONE -> IDLE unconditionally.
- Latency: start sampled high at edge 0 gives LOAD in cycle 1, ADD/SHIFT pairs in cycles 2..(2*WIDTH_M+1), and DONE in cycle 2*WIDTH_M+2 (cycle 34 for the default). Back-to-back throughput is one operation per 2*WIDTH_M+3 cycles.
- start while not in IDLE (including DONE) is ignored and is not queued. start held high continuously re-launches in the first IDLE cycle after DONE.
- Reset: state=IDLE and bit_count=0 on the next edge. Outputs after reset: ready=1, all other outputs 0. Reset mid-operation discards the operation and produces no done.
- abort: in LOAD/ADD/SHIFT, abort=1 forces IDLE at the next edge, clears bit_count to 0 and produces no done pulse. abort in IDLE or DONE has no effect; DONE still completes.
- Priority: reset > abort > start.
- bit_count never underflows: the SHIFT cycle with bit_count=1 exits to DONE, so bit_count reads 0 in DONE and IDLE.
- Invariant: at most one of load_signal, add_signal, shift_signal is high in any cycle.

Decomposition:
- Shared package mult_pkg:
  - state enum typedef mult_state_e (IDLE, LOAD, ADD, SHIFT, DONE);
  - default WIDTH_M constant;
  - a function computing CNT_W.
- One natural sub-module, mult_bit_counter: loadable down-counter with load, decrement, clear and is_one outputs. The FSM stays in mult_controller.

Test Plan:
- Reset, then idle 5 cycles -> ready=1 and every other output 0 throughout; bit_count=0.
- start pulse with bench-model multiplier 0x000B shifting right each SHIFT -> load_signal in cycle 1, 16 ADD/SHIFT pairs, mux_signal=1 only in the ADD cycles for bits 0, 1 and 3, done high only in cycle 34, ready again in cycle 35.
- start held high for 80 cycles -> two complete operations with done in cycles 34 and 69 and LOAD in cycles 1 and 36; no starts accepted in between.
- abort asserted in the 5th SHIFT cycle -> IDLE next cycle, bit_count=0, no done; a new start then gives a full 34-cycle run.
- reset asserted during ADD with start=1 -> IDLE next cycle, outputs at reset values, no done; start during DONE is ignored and no second LOAD follows.
- Throughout all runs, check: strobes are never simultaneously high, and bit_count decrements exactly once per SHIFT from 16 down to 0.
